// File: rtl/fir_amp_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_amp_meter_if
//  Description : Sample stream, control and result bundle for the FIR
//                amplitude meter. The master drives samples and control; the
//                slave (the meter) returns status and results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_amp_meter_if #(
    parameter int WIDTH = 30,
    parameter int CNT_W = 16
);
    logic signed [WIDTH-1:0] din;
    logic                    din_valid;
    logic                    start;
    logic                    abort;
    logic [CNT_W-1:0]        settle_len;
    logic [CNT_W-1:0]        win_len;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] max_val;
    logic signed [WIDTH-1:0] min_val;
    logic [WIDTH:0]          amp_pp;

    modport master (
        output din, din_valid, start, abort, settle_len, win_len,
        input  busy, done, max_val, min_val, amp_pp
    );

    modport slave (
        input  din, din_valid, start, abort, settle_len, win_len,
        output busy, done, max_val, min_val, amp_pp
    );
endinterface
`default_nettype wire

// File: rtl/fir_amp_meter.sv
`default_nettype none
// ============================================================================
//  Module      : fir_amp_meter
//  Description : Measures peak-to-peak amplitude of a signed filter output
//                stream. Discards a settle period of valid samples, then
//                tracks running max/min over a window and publishes
//                max, min and max-min on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_amp_meter #(
    parameter int WIDTH = 30,
    parameter int CNT_W = 16
) (
    input  wire logic        clk,
    input  wire logic        n_rst,
    fir_amp_meter_if.slave   bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;

    logic [1:0]              state_q;
    logic [1:0]              state_d;
    logic [CNT_W-1:0]        settle_cnt_q;
    logic [CNT_W-1:0]        win_cnt_q;
    logic                    first_q;
    logic signed [WIDTH-1:0] run_max_q;
    logic signed [WIDTH-1:0] run_min_q;
    logic signed [WIDTH-1:0] run_max_d;
    logic signed [WIDTH-1:0] run_min_d;
    logic signed [WIDTH-1:0] max_q;
    logic signed [WIDTH-1:0] min_q;
    logic [WIDTH:0]          amp_q;
    logic [WIDTH:0]          amp_d;
    logic                    done_q;

    logic w_start_ok;
    logic w_settle_acc;
    logic w_meas_acc;
    logic w_settle_last;
    logic w_win_last;

    // Abort outranks both a new start and sample acceptance.
    assign w_start_ok    = (state_q == S_IDLE)    && bus.start     && !bus.abort;
    assign w_settle_acc  = (state_q == S_SETTLE)  && bus.din_valid && !bus.abort;
    assign w_meas_acc    = (state_q == S_MEASURE) && bus.din_valid && !bus.abort;
    assign w_settle_last = (settle_cnt_q == CNT_W'(1));
    assign w_win_last    = (win_cnt_q == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    state_d = (bus.settle_len == '0) ? S_MEASURE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (w_settle_acc && w_settle_last) begin
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (w_meas_acc && w_win_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: busy follows the state, results come from their registers.
    always_comb begin
        bus.busy    = (state_q == S_SETTLE) || (state_q == S_MEASURE);
        bus.done    = done_q;
        bus.max_val = max_q;
        bus.min_val = min_q;
        bus.amp_pp  = amp_q;
    end

    // Running extremes including the current sample; amp is one bit wider
    // so full-scale positive minus full-scale negative cannot wrap.
    always_comb begin
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        if (first_q) begin
            run_max_d = bus.din;
            run_min_d = bus.din;
        end else begin
            if (bus.din > run_max_q) run_max_d = bus.din;
            if (bus.din < run_min_q) run_min_d = bus.din;
        end
        amp_d = {run_max_d[WIDTH-1], run_max_d} - {run_min_d[WIDTH-1], run_min_d};
    end

    // Counters, running extremes, published results and the done pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            first_q      <= 1'b0;
            run_max_q    <= '0;
            run_min_q    <= '0;
            max_q        <= '0;
            min_q        <= '0;
            amp_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (w_start_ok) begin
                settle_cnt_q <= bus.settle_len;
                win_cnt_q    <= (bus.win_len == '0) ? CNT_W'(1) : bus.win_len;
                first_q      <= 1'b1;
            end
            if (w_settle_acc) begin
                settle_cnt_q <= settle_cnt_q - CNT_W'(1);
            end
            if (w_meas_acc) begin
                run_max_q <= run_max_d;
                run_min_q <= run_min_d;
                first_q   <= 1'b0;
                win_cnt_q <= win_cnt_q - CNT_W'(1);
                if (w_win_last) begin
                    max_q  <= run_max_d;
                    min_q  <= run_min_d;
                    amp_q  <= amp_d;
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fir_amp_meter.md
FIR_AMP_METER -- requirements
Module: fir_amp_meter

Interface
REQ-001 Parameter WIDTH, default 30, SHALL set the signed width of the measured filter output stream.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the settle and window length inputs.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 n_rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 din  input  WIDTH signed  SHALL carry the filter output sample.
REQ-006 din_valid  input  1  SHALL qualify din; a sample is accepted only on an edge where din_valid=1.
REQ-007 start  input  1  SHALL request one measurement; it is sampled only in IDLE.
REQ-008 abort  input  1  SHALL cancel a measurement in progress.
REQ-009 settle_len  input  CNT_W  SHALL give the number of valid samples to discard before measuring.
REQ-010 win_len  input  CNT_W  SHALL give the number of valid samples in the measurement window.
REQ-011 busy  output  1  SHALL be high while in SETTLE or MEASURE.
REQ-012 done  output  1  SHALL pulse high for exactly one cycle when a measurement completes.
REQ-013 max_val  output  WIDTH signed  SHALL hold the largest window sample of the last completed measurement.
REQ-014 min_val  output  WIDTH signed  SHALL hold the smallest window sample of the last completed measurement.
REQ-015 amp_pp  output  WIDTH+1 unsigned  SHALL hold max_val minus min_val of the last completed measurement.

Function
REQ-016 The FSM SHALL have the states IDLE, SETTLE and MEASURE.
REQ-017 In IDLE with start=1, the block SHALL latch settle_len and win_len, set busy=1 on the next edge, and go to SETTLE, or to MEASURE if settle_len=0.
REQ-018 In SETTLE, each accepted sample SHALL decrement the settle counter, and acceptance of the settle_len-th sample SHALL move the FSM to MEASURE; settle samples SHALL NOT affect max_val or min_val.
REQ-019 In MEASURE, the first accepted sample SHALL initialise the running max and min, and each later sample SHALL update them using a signed compare.
REQ-020 A latched win_len of 0 SHALL be treated as 1.
REQ-021 On the edge that accepts the win_len-th window sample, with that sample included, the block SHALL:
  - register max_val, min_val and amp_pp;
  - set done=1 and busy=0;
  - return to IDLE.
REQ-022 done SHALL fall on the following edge, and max_val, min_val and amp_pp SHALL hold until the next completion.
REQ-023 amp_pp SHALL be computed at WIDTH+1 bits so that max=2^(WIDTH-1)-1 and min=-2^(WIDTH-1) give 2^WIDTH-1 without overflow.
REQ-024 start SHALL be ignored while busy=1, and a start sampled in the cycle where done=1 SHALL begin a new measurement.
REQ-025 Changes to settle_len or win_len while busy=1 SHALL have no effect on the measurement in progress.
REQ-026 abort=1 in SETTLE or MEASURE SHALL return the FSM to IDLE on the next edge with busy=0, done=0 and the result registers unchanged; abort SHALL take priority over sample acceptance on the same edge.
REQ-027 abort in IDLE SHALL have no effect, and abort together with start in IDLE SHALL leave the block in IDLE.
REQ-028 Cycles with din_valid=0 SHALL stall the counters and leave the running max and min unchanged.

Reset
REQ-029 n_rst=0 SHALL immediately, without waiting for clk:
  - force IDLE;
  - clear busy and done to 0;
  - clear max_val, min_val, amp_pp and all counters to 0.
REQ-030 Reset asserted mid-measurement SHALL discard that measurement with no done pulse.
REQ-031 After n_rst rises, the block SHALL accept start on the first rising edge.

Verification
REQ-032 Basic window: settle_len=4, win_len=8, din_valid=1 continuously, din=100,-100,100,-100, then 5,-3,12,7,-20,0,9,1 -> settle samples ignored, max_val=12, min_val=-20, amp_pp=32, done pulses one cycle after the 8th window sample edge.
REQ-033 Gapped valid: same stimulus with din_valid toggling 1,0 -> identical results, with done delayed by the number of gap cycles.
REQ-034 Extremes at WIDTH=30: window holds 536870911 and -536870912 -> amp_pp=1073741823.
REQ-035 Zero lengths: settle_len=0, win_len=0, single sample din=-7 -> max_val=min_val=-7, amp_pp=0, done one cycle after that sample.
REQ-036 Abort and reset:
  - abort raised after 3 window samples -> busy falls, no done pulse, previous results retained;
  - n_rst pulsed low mid-window -> all outputs 0 with no clock edge.
REQ-037 Back-to-back: start held high through completion -> second measurement begins in the done cycle, and start pulses while busy are ignored.
